// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the FFT stage sequencer: stage state enum,
// default frame constants and a helper to pick one stage's count from the packed bus.
package fft_ctrl_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_READ = 1'b1
    } stage_state_t;

    localparam int DEF_N       = 16;
    localparam int DEF_SIZE    = 4;
    localparam int DEF_TIMEOUT = 256;

    // Returns bits [k*size +: size] of a packed per-stage count bus (size <= 32).
    function automatic logic [31:0] cnt_slice(input logic [63:0] bus,
                                              input int          k,
                                              input int          size);
        logic [63:0] mask;
        logic [63:0] shifted;
        mask    = (64'd1 << size) - 64'd1;
        shifted = (bus >> (k * size)) & mask;
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/stage_tracker.sv
// One FFT stage's FILL/READ sequencer: write counter, start strobe, sticky flags.
// STAGE_TIMEOUT_EN adds a per-stage READ watchdog; without it timeout stays 0.
module stage_tracker
    import fft_ctrl_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int SIZE    = DEF_SIZE,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic            done,
    input  logic            clear,
    output logic            start,
    output logic            busy,
    output logic [SIZE-1:0] cnt,
    output logic            frame_pulse,
    output logic            overrun,
    output logic            timeout,
    output stage_state_t    state
);

    stage_state_t    state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic            start_q, start_d;
    logic            pulse_q, done_acc;
    logic            overrun_q, overrun_set;
    logic            wrap;
    logic            wd_expire;

`ifdef STAGE_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q;

    assign wd_expire = (state_q == ST_READ) && !done && (wd_q == WD_W'(TIMEOUT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        done_acc    = 1'b0;
        overrun_set = 1'b0;
        wrap        = valid && (cnt_q == SIZE'(N - 1));
        if (valid) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            ST_FILL: begin
                if (wrap) begin
                    state_d = ST_READ;
                    start_d = 1'b1;
                end
            end
            ST_READ: begin
                // done retires the frame first; a same-cycle write then belongs to the next frame
                if (done) begin
                    done_acc = 1'b1;
                    if (wrap) begin
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (valid) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
        if (wd_expire) begin
            state_d = ST_FILL;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            pulse_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            pulse_q <= done_acc;
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clear) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef STAGE_TIMEOUT_EN
    always_comb begin
        wd_d = '0;
        if (start_d) begin
            wd_d = '0;
        end else if (state_q == ST_READ) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_expire) begin
                timeout_q <= 1'b1;
            end else if (clear) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign state       = state_q;
    assign busy        = (state_q == ST_READ);
    assign cnt         = cnt_q;
    assign start       = start_q;
    assign frame_pulse = pulse_q;
    assign overrun     = overrun_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Run-time start/done sequencer for a chain of STAGES FFT stages.
// Optional watchdog per stage under STAGE_TIMEOUT_EN.
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int N       = DEF_N,
    parameter int SIZE    = DEF_SIZE,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [STAGES-1:0]      valid_i,
    input  logic [STAGES-1:0]      done_i,
    input  logic                   clear_i,
    output logic [STAGES-1:0]      start_o,
    output logic [STAGES-1:0]      busy_o,
    output logic [STAGES*SIZE-1:0] fill_cnt_o,
    output logic                   frame_done_o,
    output logic                   overrun_o,
    output logic                   timeout_o,
    output logic [STAGES-1:0]      stage_state
);

    // valid_i/done_i are single-cycle strobes with no back-pressure: every
    // asserted bit is consumed in the cycle it is seen.
    logic [STAGES-1:0] pulse;
    logic [STAGES-1:0] ovr;
    logic [STAGES-1:0] tmo;
    stage_state_t      st [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_tracker #(
            .N       (N),
            .SIZE    (SIZE),
            .TIMEOUT (TIMEOUT)
        ) u_trk (
            .clk         (clk),
            .rst_n       (rst_n),
            .valid       (valid_i[k]),
            .done        (done_i[k]),
            .clear       (clear_i),
            .start       (start_o[k]),
            .busy        (busy_o[k]),
            .cnt         (fill_cnt_o[k*SIZE +: SIZE]),
            .frame_pulse (pulse[k]),
            .overrun     (ovr[k]),
            .timeout     (tmo[k]),
            .state       (st[k])
        );
        assign stage_state[k] = (st[k] == ST_READ);
    end

    // Only the final stage's completion marks a whole frame through the chain.
    logic unused_pulse;
    assign unused_pulse = ^pulse[STAGES-1:0] ^ pulse[STAGES-1];
    assign frame_done_o = pulse[STAGES-1];
    assign overrun_o    = |ovr;
    assign timeout_o    = |tmo;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed + random bench for fft_stage_sequencer against a per-stage frame model.
// Honours STAGE_TIMEOUT_EN the same way the RTL build does.
module tb_fft_stage_sequencer;
    import fft_ctrl_pkg::*;

    localparam int STAGES  = 4;
    localparam int N       = 16;
    localparam int SIZE    = 4;
    localparam int TIMEOUT = 256;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [STAGES-1:0]      valid_i = '0;
    logic [STAGES-1:0]      done_i = '0;
    logic                   clear_i = 1'b0;
    logic [STAGES-1:0]      start_o;
    logic [STAGES-1:0]      busy_o;
    logic [STAGES*SIZE-1:0] fill_cnt_o;
    logic                   frame_done_o;
    logic                   overrun_o;
    logic                   timeout_o;
    logic [STAGES-1:0]      stage_state;

    always #5 clk = ~clk;

    fft_stage_sequencer #(
        .STAGES (STAGES), .N (N), .SIZE (SIZE), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .done_i       (done_i),
        .clear_i      (clear_i),
        .start_o      (start_o),
        .busy_o       (busy_o),
        .fill_cnt_o   (fill_cnt_o),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o),
        .stage_state  (stage_state)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per stage, "is a frame being read", samples written so far
    // (mod N) and READ cycles spent; plus the expected one-cycle and sticky outputs.
    bit m_rd    [STAGES];
    int m_cnt   [STAGES];
    int m_wd    [STAGES];
    bit m_start [STAGES];
    bit m_fd, m_ovr, m_to;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int k = 0; k < STAGES; k++) begin
            m_rd[k] = 0; m_cnt[k] = 0; m_wd[k] = 0; m_start[k] = 0;
        end
        m_fd = 0; m_ovr = 0; m_to = 0;
    endfunction

    // A sample landing in a stage that is collecting a frame.
    function automatic void fill_write(input int k);
        m_cnt[k] = (m_cnt[k] + 1) % N;
        if (m_cnt[k] == 0) begin
            m_rd[k] = 1; m_start[k] = 1; m_wd[k] = 0;
        end
    endfunction

    function automatic void mdl_step(input logic [STAGES-1:0] v, input logic [STAGES-1:0] d,
                                     input logic c);
        bit ovr_set = 0;
        bit to_set  = 0;
        m_fd = 0;
        for (int k = 0; k < STAGES; k++) begin
            m_start[k] = 0;
            if (!m_rd[k]) begin
                if (v[k]) fill_write(k);
            end else if (d[k]) begin
                m_rd[k] = 0;
                if (k == STAGES - 1) m_fd = 1;
                if (v[k]) fill_write(k);
            end else begin
                if (v[k]) begin
                    m_cnt[k] = (m_cnt[k] + 1) % N;
                    ovr_set = 1;
                end
`ifdef STAGE_TIMEOUT_EN
                m_wd[k]++;
                if (m_wd[k] == TIMEOUT) begin
                    to_set = 1; m_rd[k] = 0; m_cnt[k] = 0;
                end
`endif
            end
        end
        m_ovr = ovr_set | (m_ovr & ~c);
        m_to  = to_set  | (m_to  & ~c);
    endfunction

    task automatic check_all();
        for (int k = 0; k < STAGES; k++) begin
            chk($sformatf("start[%0d]", k), 64'(start_o[k]), 64'(m_start[k]));
            chk($sformatf("busy[%0d]", k), 64'(busy_o[k]), 64'(m_rd[k]));
            chk($sformatf("state[%0d]", k), 64'(stage_state[k]), 64'(m_rd[k]));
            chk($sformatf("cnt[%0d]", k), 64'(cnt_slice(64'(fill_cnt_o), k, SIZE)), 64'(m_cnt[k]));
        end
        chk("frame_done", 64'(frame_done_o), 64'(m_fd));
        chk("overrun", 64'(overrun_o), 64'(m_ovr));
        chk("timeout", 64'(timeout_o), 64'(m_to));
    endtask

    task automatic step(input logic [STAGES-1:0] v, input logic [STAGES-1:0] d, input logic c);
        valid_i = v; done_i = d; clear_i = c;
        @(posedge clk);
        mdl_step(v, d, c);
        #1;
        check_all();
        valid_i = '0; done_i = '0; clear_i = 1'b0;
    endtask

    task automatic fill_frame(input int k);
        for (int i = 0; i < N; i++) step(STAGES'(1) << k, '0, 1'b0);
    endtask

    initial begin
        // reset
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // full frame on stage 0: start exactly once, count back at 0
        for (int i = 0; i < N; i++) begin
            step(4'b0001, '0, 1'b0);
            if (i < N - 1) chk("no_early_start0", 64'(start_o[0]), 64'd0);
        end
        chk("start0_on_16th", 64'(start_o[0]), 64'd1);
        chk("busy0_after_16th", 64'(busy_o[0]), 64'd1);
        step('0, '0, 1'b0);
        chk("start0_single", 64'(start_o[0]), 64'd0);

        // final stage done -> frame_done one pulse
        fill_frame(3);
        step('0, 4'b1000, 1'b0);
        chk("frame_done_pulse", 64'(frame_done_o), 64'd1);
        chk("busy3_fall", 64'(busy_o[3]), 64'd0);
        step('0, '0, 1'b0);
        chk("frame_done_once", 64'(frame_done_o), 64'd0);

        // overrun on stage 1, sticky, clear, set beats clear
        fill_frame(1);
        step(4'b0010, '0, 1'b0);
        chk("overrun_set", 64'(overrun_o), 64'd1);
        step('0, '0, 1'b0);
        chk("overrun_sticky", 64'(overrun_o), 64'd1);
        step('0, '0, 1'b1);
        chk("overrun_clear", 64'(overrun_o), 64'd0);
        step(4'b0010, '0, 1'b1);
        chk("overrun_set_wins", 64'(overrun_o), 64'd1);
        step('0, 4'b0010, 1'b1);

        // same-cycle done+valid on stage 2 in READ
        fill_frame(2);
        step(4'b0100, 4'b0100, 1'b0);
        chk("busy2_done", 64'(busy_o[2]), 64'd0);
        chk("cnt2_first", 64'(cnt_slice(64'(fill_cnt_o), 2, SIZE)), 64'd1);
        chk("no_overrun_done_valid", 64'(overrun_o), 64'd0);

        // async reset mid-frame on stage 0
        step('0, 4'b0001, 1'b0);
        for (int i = 0; i < 10; i++) step(4'b0001, '0, 1'b0);
        rst_n = 1'b0;
        #2;
        mdl_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        fill_frame(0);
        chk("start0_after_reset", 64'(start_o[0]), 64'd1);

        // stage 0 left in READ with no done
        for (int i = 0; i < TIMEOUT + 4; i++) step('0, '0, 1'b0);
`ifdef STAGE_TIMEOUT_EN
        chk("timeout_set", 64'(timeout_o), 64'd1);
        chk("busy0_timeout", 64'(busy_o[0]), 64'd0);
`else
        chk("busy0_holds", 64'(busy_o[0]), 64'd1);
        chk("timeout_tied", 64'(timeout_o), 64'd0);
`endif
        step('0, 4'b0001, 1'b1);

        // random traffic on all stages
        for (int i = 0; i < 1500; i++) begin
            logic [STAGES-1:0] v, d;
            logic c;
            v = STAGES'($urandom_range(0, 15)) & STAGES'($urandom_range(0, 15));
            d = '0;
            for (int k = 0; k < STAGES; k++) d[k] = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 15) == 0);
            step(v, d, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
